nice_icb_arb: RTL

Shares the single NICE ICB memory port of `e203_subsys_nice_core` among the matrix-multiply engine's internal masters: LHS loader, RHS loader and output store. It arbitrates command requests, records the issuing requester of each accepted command in an in-order outstanding-ID FIFO, and steers each returning ICB response back to that requester. It also drives `nice_mem_holdup` while any transaction is pending.

---
 rtl/nice_icb_arb_if.sv | 54 +++++
 rtl/nice_icb_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nice_icb_arb_if.sv
// Bus bundle between the matrix-engine requesters, the arbiter and the NICE ICB port.
// slave: the arbiter's view; master: the environment driving requesters and memory.
interface nice_icb_arb_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    localparam int unsigned MW = DW / 8;

    logic [N_REQ-1:0]    req_cmd_valid;
    logic [N_REQ-1:0]    req_cmd_ready;
    logic [N_REQ*AW-1:0] req_cmd_addr;
    logic [N_REQ-1:0]    req_cmd_read;
    logic [N_REQ*DW-1:0] req_cmd_wdata;
    logic [N_REQ*MW-1:0] req_cmd_wmask;
    logic [N_REQ-1:0]    req_rsp_valid;
    logic [N_REQ-1:0]    req_rsp_ready;
    logic [DW-1:0]       req_rsp_rdata;
    logic                req_rsp_err;

    logic                nice_icb_cmd_valid;
    logic                nice_icb_cmd_ready;
    logic [AW-1:0]       nice_icb_cmd_addr;
    logic                nice_icb_cmd_read;
    logic [DW-1:0]       nice_icb_cmd_wdata;
    logic [MW-1:0]       nice_icb_cmd_wmask;
    logic                nice_icb_rsp_valid;
    logic                nice_icb_rsp_ready;
    logic [DW-1:0]       nice_icb_rsp_rdata;
    logic                nice_icb_rsp_err;

    logic                nice_mem_holdup;
    logic                arb_orphan_err;

    modport slave (
        input  req_cmd_valid, req_cmd_addr, req_cmd_read, req_cmd_wdata, req_cmd_wmask,
        input  req_rsp_ready,
        output req_cmd_ready, req_rsp_valid, req_rsp_rdata, req_rsp_err,
        output nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
        output nice_icb_cmd_wdata, nice_icb_cmd_wmask, nice_icb_rsp_ready,
        input  nice_icb_cmd_ready, nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err,
        output nice_mem_holdup, arb_orphan_err
    );

    modport master (
        output req_cmd_valid, req_cmd_addr, req_cmd_read, req_cmd_wdata, req_cmd_wmask,
        output req_rsp_ready,
        input  req_cmd_ready, req_rsp_valid, req_rsp_rdata, req_rsp_err,
        input  nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
        input  nice_icb_cmd_wdata, nice_icb_cmd_wmask, nice_icb_rsp_ready,
        output nice_icb_cmd_ready, nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err,
        input  nice_mem_holdup, arb_orphan_err
    );
endinterface

// File: rtl/nice_icb_arb.sv
// nice_icb_arb: shares the single NICE ICB port among the LHS loader (0), RHS loader (1)
// and output store (2). Commands are arbitrated, the issuer ID is queued in order, and
// each response is steered back to the ID at the queue head.
// Build option: define NICE_ICB_ARB_FIXED_PRIO_EN for fixed priority (highest index wins)
// instead of round-robin. Interface widths must match this module's parameters.
module nice_icb_arb #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned OUTS_DEPTH = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          nice_clk,
    input  logic          nice_rst,
    nice_icb_arb_if.slave bus
);
    localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned FPW = $clog2(OUTS_DEPTH);
    localparam int unsigned CW  = FPW + 1;
    localparam int unsigned MW  = DW / 8;

    logic [PW-1:0]  r_fifo [OUTS_DEPTH];
    logic [FPW-1:0] r_wr_ptr;
    logic [FPW-1:0] r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_lock;
    logic [PW-1:0]  r_lock_id;
    logic           r_orphan_err;
`ifndef NICE_ICB_ARB_FIXED_PRIO_EN
    logic [PW-1:0]  r_rr_ptr;
    logic [PW-1:0]  w_rr_idx;
`endif

    logic [PW-1:0]  w_grant;
    logic [PW-1:0]  w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_valid_g;
    logic           w_cmd_valid;
    logic           w_cmd_hs;
    logic           w_rsp_ready;
    logic           w_pop;
    logic           w_orphan;
    logic [AW-1:0]  w_addr;
    logic           w_read;
    logic [DW-1:0]  w_wdata;
    logic [MW-1:0]  w_wmask;

    assign w_full  = (r_count == CW'(OUTS_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Grant: pinned to lock_id while a presented command waits, otherwise arbitrate
    always_comb begin
        w_grant = '0;
`ifdef NICE_ICB_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req_cmd_valid[PW'(i)]) w_grant = PW'(i);
        end
`else
        w_rr_idx = '0;
        // Descending scan so the candidate closest to rr_ptr is written last and wins
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            w_rr_idx = PW'((int'(r_rr_ptr) + k) % int'(N_REQ));
            if (bus.req_cmd_valid[w_rr_idx]) w_grant = w_rr_idx;
        end
`endif
        if (r_lock) w_grant = r_lock_id;
    end

    // Command mux from the granted requester, per-requester readies and response steering
    always_comb begin
        w_valid_g         = 1'b0;
        w_addr            = '0;
        w_read            = 1'b0;
        w_wdata           = '0;
        w_wmask           = '0;
        w_rsp_ready       = 1'b1;
        bus.req_cmd_ready = '0;
        bus.req_rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant == PW'(i)) begin
                w_valid_g = bus.req_cmd_valid[PW'(i)];
                w_addr    = bus.req_cmd_addr[i*AW +: AW];
                w_read    = bus.req_cmd_read[PW'(i)];
                w_wdata   = bus.req_cmd_wdata[i*DW +: DW];
                w_wmask   = bus.req_cmd_wmask[i*MW +: MW];
            end
            bus.req_cmd_ready[PW'(i)] = (w_grant == PW'(i)) && !w_full && bus.nice_icb_cmd_ready;
            bus.req_rsp_valid[PW'(i)] = !w_empty && (w_head == PW'(i)) && bus.nice_icb_rsp_valid;
            if (!w_empty && (w_head == PW'(i))) w_rsp_ready = bus.req_rsp_ready[PW'(i)];
        end
    end

    assign w_cmd_valid = w_valid_g && !w_full && (|bus.req_cmd_valid);
    assign w_cmd_hs    = w_cmd_valid && bus.nice_icb_cmd_ready;
    assign w_pop       = !w_empty && bus.nice_icb_rsp_valid && w_rsp_ready;
    assign w_orphan    = w_empty && bus.nice_icb_rsp_valid;

    assign bus.nice_icb_cmd_valid = w_cmd_valid;
    assign bus.nice_icb_cmd_addr  = w_addr;
    assign bus.nice_icb_cmd_read  = w_read;
    assign bus.nice_icb_cmd_wdata = w_wdata;
    assign bus.nice_icb_cmd_wmask = w_wmask;
    assign bus.nice_icb_rsp_ready = w_rsp_ready;
    assign bus.req_rsp_rdata      = bus.nice_icb_rsp_rdata;
    assign bus.req_rsp_err        = bus.nice_icb_rsp_err;
    assign bus.nice_mem_holdup    = w_cmd_valid || !w_empty;
    assign bus.arb_orphan_err     = r_orphan_err;

    // Control state: lock, grant pointer, ID queue pointers/count, sticky orphan flag
    always_ff @(posedge nice_clk) begin
        if (nice_rst) begin
            r_lock       <= 1'b0;
            r_lock_id    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_orphan_err <= 1'b0;
`ifndef NICE_ICB_ARB_FIXED_PRIO_EN
            r_rr_ptr     <= '0;
`endif
        end else begin
            // Hold the grant while the chosen requester waits, including while the queue is full
            r_lock    <= w_valid_g && !w_cmd_hs;
            r_lock_id <= w_grant;
            if (w_cmd_hs) r_wr_ptr <= r_wr_ptr + FPW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + FPW'(1);
            if (w_cmd_hs && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_cmd_hs && w_pop) r_count <= r_count - CW'(1);
            if (w_orphan) r_orphan_err <= 1'b1;
`ifndef NICE_ICB_ARB_FIXED_PRIO_EN
            if (w_cmd_hs) r_rr_ptr <= (w_grant == PW'(N_REQ - 1)) ? '0 : w_grant + PW'(1);
`endif
        end
    end

    // ID storage; entries are only read while count says they are live
    always_ff @(posedge nice_clk) begin
        if (w_cmd_hs) r_fifo[r_wr_ptr] <= w_grant;
    end
endmodule
